// File: rtl/cacheline_adaptor.sv
// Bridges a cache's whole-line read/write requests to a memory that moves the line
// as s_line/s_burst beats, lowest beat first, one beat per resp_i strobe.
module cacheline_adaptor #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,

    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int beats = s_line / s_burst;
    localparam int cnt_w = $clog2(beats);
    localparam int off_w = $clog2(s_line / 8);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t             state, state_next;
    logic [cnt_w-1:0]   cnt_q;
    logic [31:0]        addr_q;
    logic [s_line-1:0]  wline_q;
    logic [s_line-1:0]  rline_q;
    logic [31:0]        line_addr;
    logic               last_beat;

    assign line_addr = {address_i[31:off_w], {off_w{1'b0}}};
    assign last_beat = (cnt_q == cnt_w'(beats - 1));

    // NOTE: state updates use <= so every register samples pre-edge values; blocking
    // assignments here would let later statements see half-updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: both line buffers are reset because their contents are visible on
            // line_o/burst_o and must read as zero after reset or an aborted read.
            state   <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (write_i) begin
                        wline_q <= line_i;
                        addr_q  <= line_addr;
                        cnt_q   <= '0;
                    end else if (read_i) begin
                        addr_q  <= line_addr;
                        cnt_q   <= '0;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        rline_q[cnt_q*s_burst +: s_burst] <= burst_i;
                        cnt_q <= cnt_q + cnt_w'(1);
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        cnt_q <= cnt_q + cnt_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        read_o     = 1'b0;
        write_o    = 1'b0;
        resp_o     = 1'b0;
        case (state)
            IDLE: begin
                if (write_i) begin
                    state_next = WRITE;
                end else if (read_i) begin
                    state_next = READ;
                end
            end
            READ: begin
                read_o = 1'b1;
                if (resp_i && last_beat) begin
                    state_next = DONE;
                end
            end
            WRITE: begin
                write_o = 1'b1;
                if (resp_i && last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                resp_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign address_o = addr_q;
    assign burst_o   = wline_q[cnt_q*s_burst +: s_burst];
    assign line_o    = rline_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: a behavioural memory feeds/consumes beats
// from queues filled when each request is issued.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int checks   = 0;
    int failures = 0;

    logic [63:0]  beat_q[$];
    logic [255:0] line_q[$];
    logic [255:0] last_line;

    cacheline_adaptor #(.s_line(256), .s_burst(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    // Idle cycle: outputs quiet, then present the request (and a stray resp_i to be ignored).
    task automatic start(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] line, input string name);
        @(negedge clk);
        checks++;
        if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0) begin
            failures++;
            $display("FAIL %s idle: resp_o=%b read_o=%b write_o=%b required 0/0/0",
                     name, resp_o, read_o, write_o);
        end
        read_i    = rd;
        write_i   = wr;
        address_i = addr;
        line_i    = line;
        resp_i    = 1'b1;
        burst_i   = {$urandom, $urandom};
    endtask

    // Runs one accepted transaction; pat bit i drives resp_i in cycle i+1, then 1 beyond plen.
    task automatic serve(input bit is_wr, input logic [31:0] exp_addr, input logic [15:0] pat,
                         input int plen, input bit keep_rd, input string name);
        int           nb;
        int           exp_done;
        bit           done;
        bit           r;
        logic [255:0] exp_line;
        nb       = 0;
        exp_done = 0;
        for (int i = 0; i < 64 && nb < 4; i++) begin
            if (i >= plen || pat[i % 16]) begin
                nb++;
                if (nb == 4) exp_done = i + 2;
            end
        end
        done = 1'b0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                write_i   = 1'b0;
                if (!keep_rd) read_i = 1'b0;
                address_i = $urandom;
                for (int k = 0; k < 8; k++) line_i[k*32 +: 32] = $urandom;
            end
            if (resp_o === 1'b1) begin
                done   = 1'b1;
                resp_i = 1'b0;
                checks++;
                if (cyc != exp_done) begin
                    failures++;
                    $display("FAIL %s resp_cycle: got %0d required %0d", name, cyc, exp_done);
                end
                checks++;
                if (read_o !== 1'b0 || write_o !== 1'b0) begin
                    failures++;
                    $display("FAIL %s done_strobes: read_o=%b write_o=%b required 0/0",
                             name, read_o, write_o);
                end
                if (!is_wr) begin
                    exp_line = line_q.pop_front();
                    last_line = exp_line;
                    checks++;
                    if (line_o !== exp_line) begin
                        failures++;
                        $display("FAIL %s line_o: got %h required %h", name, line_o, exp_line);
                    end
                end
            end else begin
                checks++;
                if (read_o !== !is_wr || write_o !== is_wr || address_o !== exp_addr) begin
                    failures++;
                    $display("FAIL %s busy: read_o=%b write_o=%b address_o=%h required %b/%b/%h",
                             name, read_o, write_o, address_o, !is_wr, is_wr, exp_addr);
                end
                r = (cyc - 1 >= plen) || pat[(cyc - 1) % 16];
                if (beat_q.size() == 0) begin
                    failures++;
                    checks++;
                    $display("FAIL %s extra_beat: cycle %0d busy with no beats left", name, cyc);
                    resp_i = 1'b0;
                end else begin
                    resp_i = r;
                    if (is_wr) begin
                        checks++;
                        if (burst_o !== beat_q[0]) begin
                            failures++;
                            $display("FAIL %s burst_o: got %h required %h", name, burst_o, beat_q[0]);
                        end
                    end else begin
                        burst_i = beat_q[0];
                    end
                    if (r) void'(beat_q.pop_front());
                end
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: resp_o=%b required 1 within 40 cycles", name, resp_o);
            resp_i = 1'b0;
            beat_q.delete();
            line_q.delete();
        end
    endtask

    task automatic push_line(input logic [255:0] line, input bit is_rd);
        for (int i = 0; i < 4; i++) beat_q.push_back(line[i*64 +: 64]);
        if (is_rd) line_q.push_back(line);
    endtask

    task automatic test_reset();
        rst = 1'b1; read_i = 1'b1; write_i = 1'b1; resp_i = 1'b1;
        address_i = 32'hFFFF_FFFF; line_i = '1; burst_i = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin
            failures++;
            $display("FAIL reset strobes: read_o=%b write_o=%b resp_o=%b required 0/0/0",
                     read_o, write_o, resp_o);
        end
        checks++;
        if (address_o !== 32'h0 || burst_o !== 64'h0 || line_o !== 256'h0) begin
            failures++;
            $display("FAIL reset data: address_o=%h burst_o=%h line_o=%h required all zero",
                     address_o, burst_o, line_o);
        end
        rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        last_line = '0;
    endtask

    task automatic test_read(input logic [31:0] addr, input logic [255:0] line,
                             input logic [15:0] pat, input int plen, input string name);
        push_line(line, 1'b1);
        start(1'b1, 1'b0, addr, '0, name);
        serve(1'b0, addr & 32'hFFFF_FFE0, pat, plen, 1'b0, name);
    endtask

    task automatic test_write(input logic [31:0] addr, input logic [255:0] line,
                              input logic [15:0] pat, input int plen, input string name);
        push_line(line, 1'b0);
        start(1'b0, 1'b1, addr, line, name);
        serve(1'b1, addr & 32'hFFFF_FFE0, pat, plen, 1'b0, name);
        checks++;
        if (line_o !== last_line) begin
            failures++;
            $display("FAIL %s line_hold: got %h required %h", name, line_o, last_line);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] wl, rl;
        wl = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0};
        rl = {64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 64'h1234_1234_1234_1234, 64'h9876_9876_9876_9876};
        push_line(wl, 1'b0);
        start(1'b1, 1'b1, 32'h0000_1234, wl, "b2b_req");
        serve(1'b1, 32'h0000_1220, 16'hFFFF, 4, 1'b1, "b2b_write");
        push_line(rl, 1'b1);
        start(1'b1, 1'b0, 32'h0000_5678, '0, "b2b_gap");
        serve(1'b0, 32'h0000_5660, 16'hFFFF, 4, 1'b0, "b2b_read");
    endtask

    task automatic test_reset_abort();
        start(1'b1, 1'b0, 32'h0000_4040, '0, "abort");
        for (int cyc = 1; cyc <= 2; cyc++) begin
            @(negedge clk);
            read_i = 1'b0;
            checks++;
            if (read_o !== 1'b1) begin
                failures++;
                $display("FAIL abort read_o: got %b required 1 in cycle %0d", read_o, cyc);
            end
            resp_i  = 1'b1;
            burst_i = {2{$urandom}} | 64'h1;
        end
        @(negedge clk);
        rst = 1'b1; resp_i = 1'b0;
        @(negedge clk);
        checks++;
        if (read_o !== 1'b0 || resp_o !== 1'b0 || line_o !== 256'h0 || address_o !== 32'h0) begin
            failures++;
            $display("FAIL abort state: read_o=%b resp_o=%b line_o=%h address_o=%h required 0/0/0/0",
                     read_o, resp_o, line_o, address_o);
        end
        rst = 1'b0;
        last_line = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (resp_o !== 1'b0 || read_o !== 1'b0) begin
                failures++;
                $display("FAIL abort quiet: resp_o=%b read_o=%b required 0/0", resp_o, read_o);
            end
        end
        test_read(32'h0000_4044, {64'hCAFE_0003_CAFE_0003, 64'hCAFE_0002_CAFE_0002,
                                  64'hCAFE_0001_CAFE_0001, 64'hCAFE_0000_CAFE_0000},
                  16'hFFFF, 4, "after_abort");
    endtask

    initial begin
        test_reset();
        test_read(32'h8000_8088, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                  16'hFFFF, 4, "read");
        test_write(32'h0000_8080, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                   64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                   16'hFFFF, 4, "write");
        test_read(32'h1234_567F, {64'hA0A0_0000_0000_0004, 64'hB0B0_0000_0000_0003,
                                  64'hC0C0_0000_0000_0002, 64'hD0D0_0000_0000_0001},
                  16'h0069, 7, "read_stall");
        test_write(32'h7654_3210, {64'h0000_0000_DEAD_0004, 64'h0000_0000_DEAD_0003,
                                   64'h0000_0000_DEAD_0002, 64'h0000_0000_DEAD_0001},
                   16'h003C, 6, "write_stall");
        test_back_to_back();
        test_reset_abort();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 The block SHALL have parameter s_line, default 256, cache line width in bits.
REQ-002 The block SHALL have parameter s_burst, default 64, memory beat width in bits; beats per line = s_line/s_burst = 4.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port line_i  input  s_line  writeback line from cache (pmem_wdata).
REQ-006 Port line_o  output  s_line  fill line to cache (pmem_rdata).
REQ-007 Port address_i  input  32  line request address from cache (pmem_address).
REQ-008 Port read_i  input  1  cache line read request (pmem_read).
REQ-009 Port write_i  input  1  cache line write request (pmem_write).
REQ-010 Port resp_o  output  1  one-cycle completion pulse to cache (pmem_resp).
REQ-011 Port burst_i  input  s_burst  read beat from memory.
REQ-012 Port burst_o  output  s_burst  write beat to memory.
REQ-013 Port address_o  output  32  burst base address to memory.
REQ-014 Port read_o  output  1  burst read request to memory.
REQ-015 Port write_o  output  1  burst write request to memory.
REQ-016 Port resp_i  input  1  memory beat accept/valid strobe.

Function
REQ-017 The FSM SHALL have states IDLE, READ, WRITE, DONE; a 2-bit beat counter SHALL index beats 0..3.
REQ-018 In IDLE, write_i=1 SHALL latch line_i and {address_i[31:5],5'b0}, clear counter, go WRITE; write takes priority when read_i and write_i are both 1.
REQ-019 In IDLE, read_i=1 with write_i=0 SHALL latch aligned address, clear counter, go READ.
REQ-020 In IDLE, resp_i SHALL be ignored and read_o/write_o SHALL be 0.
REQ-021 In READ, read_o=1 and address_o=latched address every cycle; each cycle with resp_i=1 SHALL store burst_i into line bits [64*cnt+63:64*cnt] and increment cnt.
REQ-022 In WRITE, write_o=1, address_o=latched address, burst_o=latched line bits [64*cnt+63:64*cnt]; each resp_i=1 cycle SHALL increment cnt.
REQ-023 Beats SHALL be ordered low to high (beat 0 = bits [63:0]); resp_i gaps SHALL stall the counter without loss.
REQ-024 The resp_i on beat 3 SHALL move READ/WRITE to DONE; read_o/write_o SHALL be 0 in DONE.
REQ-025 In DONE, resp_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-026 line_o SHALL present the assembled read line in DONE and hold it until the next READ begins.
REQ-027 Requests SHALL be sampled only in IDLE; read_i/write_i still high in the cycle after DONE SHALL start a new transaction.
REQ-028 Latency: request accepted at edge 0; with resp_i on 4 consecutive cycles starting at cycle k, resp_o SHALL be 1 in cycle k+4.
REQ-029 address_i and line_i changes after acceptance SHALL NOT affect the transaction in progress.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, cnt=0, resp_o=0, read_o=0, write_o=0, address_o=0, burst_o=0, line_o=0.
REQ-031 rst mid-READ/WRITE SHALL abort the transaction without a resp_o pulse; partially assembled data SHALL be discarded.

Verification
REQ-032 Read: address_i=0x8000_8088, read_i=1; memory returns beats 0x11..,0x22..,0x33..,0x44.. on 4 consecutive resp_i -> address_o=0x8000_8080, line_o={0x44..,0x33..,0x22..,0x11..}, resp_o single pulse at k+4.
REQ-033 Write: address_i=0x0000_8080, line_i=0xDDDD..CCCC..BBBB..AAAA.. -> write_o high, burst_o sequence AAAA..,BBBB..,CCCC..,DDDD.., resp_o one pulse after beat 3.
REQ-034 Stalled beats: resp_i pattern 1,0,0,1,0,1,1 -> counter holds on 0 cycles, correct line assembled, resp_o after 4th resp_i.
REQ-035 Simultaneous read_i=write_i=1 -> write burst first, then read burst starts the cycle after DONE; two resp_o pulses total.
REQ-036 rst asserted after beat 1 of a read -> next cycle read_o=0, resp_o never pulses, line_o=0; new read afterwards completes normally.
